// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback has absolute priority, and aux
// writes queue in an in-order FIFO that is squashed by younger pipeline writes.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] P_Data,
  input  logic [4:0]  P_WriteSelect,
  input  logic        P_WriteEnable,
  input  logic        A_Valid,
  input  logic [31:0] A_Data,
  input  logic [4:0]  A_WriteSelect,
  output logic        A_Ready,
  output logic [31:0] RF_Data,
  output logic [4:0]  RF_WriteSelect,
  output logic        RF_WriteEnable,
  output logic [31:0] Pending,
  output logic        Stall
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [31:0]      data_q [DEPTH];
  logic [4:0]       sel_q  [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic [31:0]      rf_data_q, rf_data_d;
  logic [4:0]       rf_sel_q, rf_sel_d;
  logic             rf_we_q, rf_we_d;

  logic        p_req, head_busy, head_ok, grant, discard, lose, push, pop;
  logic [31:0] pend;

  assign p_req     = P_WriteEnable && (P_WriteSelect != 5'd0);
  assign head_busy = (count_q != '0);
  assign head_ok   = head_busy && live_q[rd_ptr_q] && (sel_q[rd_ptr_q] != 5'd0);
  assign discard   = head_busy && !head_ok;
  assign grant     = head_ok && !p_req;
  assign lose      = head_ok && p_req;
  assign pop       = grant || discard;
  assign A_Ready   = !rst && (count_q < DEPTH_C);
  assign push      = A_Valid && A_Ready;

  // Popped slots are marked dead, so live_q alone identifies occupied live entries.
  always_comb begin
    pend = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (live_q[k]) pend[sel_q[k]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign Pending = pend;
  assign Stall   = (starve_q == LIMIT_C);

  always_comb begin
    live_d = live_q;
    if (pop) live_d[rd_ptr_q] = 1'b0;
    if (p_req) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (sel_q[k] == P_WriteSelect) live_d[k] = 1'b0;
      end
    end
    // A same-edge push is older than the concurrent pipeline write, so it is born dead.
    if (push) live_d[wr_ptr_q] = !(p_req && (A_WriteSelect == P_WriteSelect));
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_comb begin
    starve_d = starve_q;
    if (!head_busy || grant || discard) starve_d = '0;
    else if (lose && (starve_q != LIMIT_C)) starve_d = starve_q + 1'b1;
  end

  always_comb begin
    rf_data_d = rf_data_q;
    rf_sel_d  = rf_sel_q;
    rf_we_d   = 1'b0;
    if (p_req) begin
      rf_data_d = P_Data;
      rf_sel_d  = P_WriteSelect;
      rf_we_d   = 1'b1;
    end else if (grant) begin
      rf_data_d = data_q[rd_ptr_q];
      rf_sel_d  = sel_q[rd_ptr_q];
      rf_we_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      rf_data_q <= '0;
      rf_sel_q  <= '0;
      rf_we_q   <= 1'b0;
    end else begin
      live_q    <= live_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      rf_data_q <= rf_data_d;
      rf_sel_q  <= rf_sel_d;
      rf_we_q   <= rf_we_d;
    end
  end

  // Payload storage needs no reset: live_q gates every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= A_Data;
      sel_q[wr_ptr_q]  <= A_WriteSelect;
    end
  end

  assign RF_Data        = rf_data_q;
  assign RF_WriteSelect = rf_sel_q;
  assign RF_WriteEnable = rf_we_q;

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, aux write buffer entries (power of two, 2..8).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive lost cycles before Stall asserts.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port P_Data  input  32  pipeline writeback data.
REQ-006 SHALL have port P_WriteSelect  input  5  pipeline destination register.
REQ-007 SHALL have port P_WriteEnable  input  1  pipeline write request, this cycle.
REQ-008 SHALL have port A_Valid  input  1  aux (multi-cycle unit) write offered.
REQ-009 SHALL have port A_Data  input  32  aux write data.
REQ-010 SHALL have port A_WriteSelect  input  5  aux destination register.
REQ-011 SHALL have port A_Ready  output  1  buffer can accept; push = A_Valid && A_Ready at posedge.
REQ-012 SHALL have port RF_Data  output  32  registered register-file write data.
REQ-013 SHALL have port RF_WriteSelect  output  5  registered register-file write address.
REQ-014 SHALL have port RF_WriteEnable  output  1  registered register-file write strobe.
REQ-015 SHALL have port Pending  output  32  bit i = live aux write to register i buffered.
REQ-016 SHALL have port Stall  output  1  request upstream to insert a writeback bubble.

Function
REQ-017 SHALL buffer aux writes in an in-order FIFO of DEPTH entries, each {data, select, live}; live=0 marks a squashed entry.
REQ-018 SHALL drive A_Ready = !rst && (count < DEPTH), from registered count only; no push when full even if a pop occurs that cycle.
REQ-019 SHALL give the pipeline absolute priority: P_WriteEnable=1 with P_WriteSelect!=0 in cycle t -> RF_* = {P_Data, P_WriteSelect, 1} in cycle t+1.
REQ-020 SHALL treat P_WriteEnable=1 with P_WriteSelect=0 as no request (register 0 hardwired); RF_WriteEnable=0 at t+1 unless aux granted.
REQ-021 SHALL grant the FIFO head when it is live, select!=0 and there is no pipeline request: pop at posedge t, RF_* = head contents at t+1.
REQ-022 SHALL discard a head that is squashed or has select=0: pop at posedge, no RF write, one per cycle, independent of pipeline activity.
REQ-023 SHALL not bypass: an entry pushed at posedge t is grant-eligible from cycle t+1 (earliest RF write cycle t+2).
REQ-024 SHALL squash on a granted pipeline write to register r: every buffered entry with select=r, and any entry pushed at the same posedge with select=r, gets live=0 (pipeline write is younger).
REQ-025 SHALL drive Pending[i]=1 iff a live buffered entry has select=i; Pending[0]=0 always; derived from registered FIFO state.
REQ-026 SHALL keep a starvation counter: +1 (saturating at STARVE_LIMIT) each cycle a live non-zero head loses to the pipeline; cleared on aux grant, on discard, or when FIFO empty.
REQ-027 SHALL assert Stall = (counter == STARVE_LIMIT); upstream is expected to hold P_WriteEnable=0 next cycle; if it does not, pipeline still wins and Stall stays high.
REQ-028 SHALL allow simultaneous push and pop in one cycle when not full; count unchanged, order preserved, pointers wrap modulo DEPTH.
REQ-029 SHALL deassert RF_WriteEnable in any cycle following a cycle with neither pipeline request nor aux grant; RF_Data/RF_WriteSelect hold last value then.

Reset
REQ-030 SHALL, when rst=1 at posedge, empty FIFO (count=0, pointers=0, all live=0), clear counter, set RF_Data=0, RF_WriteSelect=0, RF_WriteEnable=0; Pending=0, Stall=0 follow.
REQ-031 SHALL discard buffered and same-cycle pipeline/aux writes when reset is applied mid-operation; no RF write in the cycle after reset.

Verification
REQ-032 SHALL pass: pipeline writes 0xDEADBEEF to r5 at t, no aux -> RF_WriteEnable=1, RF_WriteSelect=5, RF_Data=0xDEADBEEF at t+1, then 0.
REQ-033 SHALL pass: aux push r7=0x11 at t, pipeline idle -> Pending[7]=1 at t+1, RF write r7=0x11 at t+2, Pending[7]=0 at t+2.
REQ-034 SHALL pass: two aux pushes fill DEPTH=2 -> A_Ready=0; third A_Valid held is not accepted until a pop occurs.
REQ-035 SHALL pass: aux r3 buffered, pipeline writes r3=0x22 -> r3 written 0x22 only, aux entry discarded with no RF write, Pending[3]=0.
REQ-036 SHALL pass: live aux head plus pipeline writing every cycle -> Stall=1 after 4 cycles; one pipeline bubble -> aux written next cycle, Stall=0.
REQ-037 SHALL pass: rst asserted with 2 buffered entries and pipeline request -> RF_WriteEnable=0, Pending=0, A_Ready=1 the cycle after rst drops.
